shift_arbiter: RTL



---
 rtl/shift_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-port round-robin arbiter and sequencer for one shared,
// purely combinational barrel shifter.
//   port 0 : ALU / execute path
//   port 1 : load/store byte-alignment path
// Each operation accepts a request in IDLE, presents the registered operands
// to the shifter for one EXEC cycle, then holds the registered result on the
// owner's response channel (RESP) until the consumer takes it.
// Optional build macro:
//   SHIFT_ARB_FIXED_PRIO_EN - port 0 always wins a tie (port 1 may starve);
//                             when undefined, ties alternate by round-robin.
module shift_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 2
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic [1:0]            req0_op,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic [DATA_WIDTH-1:0] rsp0_result,

   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   input  logic [1:0]            req1_op,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp1_result,

   output logic [DATA_WIDTH-1:0] sh_a,
   output logic [DATA_WIDTH-1:0] sh_b,
   output logic [1:0]            sh_op,
   input  logic [DATA_WIDTH-1:0] sh_result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Registers and their next values
   // ------------------------------------------------------------------
   state_t                  state_reg,      state_next;
   logic                    last_grant_reg, last_grant_next;
   logic                    owner_reg,      owner_next;
   logic [DATA_WIDTH-1:0]   a_reg,          a_next;
   logic [DATA_WIDTH-1:0]   b_reg,          b_next;
   logic [1:0]              op_reg,         op_next;
   logic [DATA_WIDTH-1:0]   result_reg,     result_next;

   // ------------------------------------------------------------------
   // Per-port views of the flat port list so the logic below can be
   // written once and indexed by port number.
   // ------------------------------------------------------------------
   logic [NUM_REQ-1:0]      req_valid_vec;
   logic [NUM_REQ-1:0]      req_ready_vec;
   logic [NUM_REQ-1:0]      rsp_valid_vec;
   logic [NUM_REQ-1:0]      rsp_ready_vec;
   logic [DATA_WIDTH-1:0]   req_a_arr      [NUM_REQ];
   logic [DATA_WIDTH-1:0]   req_b_arr      [NUM_REQ];
   logic [1:0]              req_op_arr     [NUM_REQ];
   logic [DATA_WIDTH-1:0]   rsp_result_arr [NUM_REQ];

   assign req_valid_vec = {req1_valid, req0_valid};
   assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

   assign req_a_arr[0]  = req0_a;
   assign req_a_arr[1]  = req1_a;
   assign req_b_arr[0]  = req0_b;
   assign req_b_arr[1]  = req1_b;
   assign req_op_arr[0] = req0_op;
   assign req_op_arr[1] = req1_op;

   assign req0_ready  = req_ready_vec[0];
   assign req1_ready  = req_ready_vec[1];
   assign rsp0_valid  = rsp_valid_vec[0];
   assign rsp1_valid  = rsp_valid_vec[1];
   assign rsp0_result = rsp_result_arr[0];
   assign rsp1_result = rsp_result_arr[1];

   // The shifter always sees the captured operands, so its inputs cannot
   // move while EXEC samples its result.
   assign sh_a  = a_reg;
   assign sh_b  = b_reg;
   assign sh_op = op_reg;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   logic [NUM_REQ-1:0] grant_vec;   // one-hot, all zero when nobody asks
   logic               grant_idx;   // index of the winning port
   logic               accept;      // a handshake completes this cycle

   // Pick at most one winner from the valid lines.
   always_comb begin
      grant_vec = '0;
      if (req_valid_vec[0] && req_valid_vec[1]) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
         grant_vec = 2'b01;
`else
         // Tie: whoever did not win last time goes now.
         grant_vec = last_grant_reg ? 2'b01 : 2'b10;
`endif
      end else if (req_valid_vec[1]) begin
         grant_vec = 2'b10;
      end else if (req_valid_vec[0]) begin
         grant_vec = 2'b01;
      end
   end

   assign grant_idx = grant_vec[1];
   assign accept    = (state_reg == IDLE) && (|(req_valid_vec & req_ready_vec));

   // ------------------------------------------------------------------
   // Per-port handshake outputs
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
         // Ready only in IDLE and only for the arbitration winner.
         always_comb begin
            req_ready_vec[gi] = (state_reg == IDLE) && grant_vec[gi];
         end

         // Response goes to the owner only; the other port sees zeros.
         always_comb begin
            rsp_valid_vec[gi]  = (state_reg == RESP) &&
                                 (owner_reg == ((gi == 1) ? 1'b1 : 1'b0));
            rsp_result_arr[gi] = rsp_valid_vec[gi] ? result_reg : '0;
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   // Next-state and register-update logic; every register holds by default.
   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      owner_next      = owner_reg;
      a_next          = a_reg;
      b_next          = b_reg;
      op_next         = op_reg;
      result_next     = result_reg;

      unique case (state_reg)
         IDLE: begin
            if (accept) begin
               // Operands are taken exactly as presented at the accept edge;
               // the full b word is kept, the shifter itself uses only [4:0].
               a_next          = req_a_arr[grant_idx];
               b_next          = req_b_arr[grant_idx];
               op_next         = req_op_arr[grant_idx];
               owner_next      = grant_idx;
               last_grant_next = grant_idx;
               state_next      = EXEC;
            end
         end
         EXEC: begin
            result_next = sh_result;
            state_next  = RESP;
         end
         RESP: begin
            if (rsp_ready_vec[owner_reg]) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;   // so port 0 wins the first tie
         owner_reg      <= 1'b0;
         a_reg          <= '0;
         b_reg          <= '0;
         op_reg         <= '0;
         result_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         owner_reg      <= owner_next;
         a_reg          <= a_next;
         b_reg          <= b_next;
         op_reg         <= op_next;
         result_reg     <= result_next;
      end
   end

endmodule
